// File: rtl/madd_eval_pkg.sv
// madd_eval_pkg: shared widths, state encoding and exact multiply-add model for the error sweep
package madd_eval_pkg;
    localparam int OP_W   = 6;
    localparam int VEC_W  = 3 * OP_W;
    localparam int RES_W  = 2 * OP_W;
    localparam int DIFF_W = RES_W + 1;
    localparam int SUM_W  = 30;
    localparam int A_LSB  = 0;
    localparam int B_LSB  = OP_W;
    localparam int C_LSB  = 2 * OP_W;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    function automatic logic [RES_W-1:0] exact_madd(input logic [VEC_W-1:0] vec);
        return RES_W'(vec[A_LSB +: OP_W]) * RES_W'(vec[B_LSB +: OP_W]) + RES_W'(vec[C_LSB +: OP_W]);
    endfunction
endpackage

// File: rtl/madd_err_acc.sv
// madd_err_acc: registered compare stage followed by count, max and sum accumulators
module madd_err_acc
    import madd_eval_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             valid,
    input  logic [RES_W-1:0] dut_out,
    input  logic [RES_W-1:0] exact,
    output logic [VEC_W:0]   vec_count,
    output logic [VEC_W:0]   err_count,
    output logic [RES_W-1:0] max_abs_err,
    output logic [SUM_W-1:0] sum_abs_err
);
    logic signed [DIFF_W-1:0] diff;
    logic [RES_W-1:0] abs_err, e_abs;
    logic e_vld;
    assign diff    = signed'({1'b0, dut_out}) - signed'({1'b0, exact});
    assign abs_err = diff[DIFF_W-1] ? RES_W'(-diff) : RES_W'(diff);
    // compare stage E, then accumulate on the following edge; a new sweep clears everything
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            e_vld       <= 1'b0;
            e_abs       <= '0;
            vec_count   <= '0;
            err_count   <= '0;
            max_abs_err <= '0;
            sum_abs_err <= '0;
        end else if (clear) begin
            e_vld       <= 1'b0;
            e_abs       <= '0;
            vec_count   <= '0;
            err_count   <= '0;
            max_abs_err <= '0;
            sum_abs_err <= '0;
        end else begin
            e_vld       <= valid;
            e_abs       <= abs_err;
            vec_count   <= vec_count + (VEC_W+1)'(e_vld);
            err_count   <= err_count + (VEC_W+1)'(e_vld && e_abs != '0);
            max_abs_err <= e_vld && e_abs > max_abs_err ? e_abs : max_abs_err;
            sum_abs_err <= sum_abs_err + (e_vld ? SUM_W'(e_abs) : '0);
        end
endmodule

// File: rtl/madd_err_sweep.sv
// madd_err_sweep: sweeps a vector range through an external multiply-add DUT and gathers error statistics
module madd_err_sweep
    import madd_eval_pkg::*;
#(
    parameter int LAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [VEC_W-1:0] vec_first,
    input  logic [VEC_W-1:0] vec_last,
    output logic [VEC_W-1:0] dut_in,
    input  logic [RES_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [VEC_W:0]   vec_count,
    output logic [VEC_W:0]   err_count,
    output logic [RES_W-1:0] max_abs_err,
    output logic [SUM_W-1:0] sum_abs_err
);
    state_t state, state_nx;
    logic [VEC_W-1:0] last, g_vec;
    logic idle, go, stop, run, g_vld, pend;
    assign idle = state == IDLE || state == DONE;
    assign go   = idle && start;
    assign stop = !idle && abort;
    assign run  = state == RUN;
    assign busy = !idle;
    // next state: start from idle wins, then abort, then sweep end and pipeline drain
    always_comb begin
        state_nx = state;
        if (go) state_nx = vec_first <= vec_last ? RUN : DONE;
        else if (stop) state_nx = IDLE;
        else if (run && dut_in == last) state_nx = DRAIN;
        else if (state == DRAIN && !pend) state_nx = DONE;
    end
    // state, range, vector counter and status flags; the counter stops at last so it never wraps
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            last    <= '0;
            dut_in  <= '0;
            done    <= 1'b0;
            aborted <= 1'b0;
        end else begin
            state   <= state_nx;
            last    <= go ? vec_last : last;
            dut_in  <= go && vec_first <= vec_last ? vec_first : run && dut_in != last ? dut_in + 1'b1 : dut_in;
            done    <= state_nx == DONE && (state != DONE || go);
            aborted <= go ? 1'b0 : stop | aborted;
        end
    if (LAT == 0) begin : g_nodly
        assign g_vec = dut_in;
        assign g_vld = run;
        assign pend  = 1'b0;
    end else begin : g_dly
        logic [VEC_W-1:0] pv [LAT];
        logic [LAT-1:0] pl;
        // golden vector follows the external DUT pipeline
        always_ff @(posedge clk) begin
            pv[0] <= dut_in;
            for (int i = 1; i < LAT; i++) pv[i] <= pv[i-1];
        end
        // valid bits in flight; abort discards them
        always_ff @(posedge clk or posedge rst)
            if (rst) pl <= '0;
            else pl <= stop ? '0 : LAT'({pl, run});
        assign g_vec = pv[LAT-1];
        assign g_vld = pl[LAT-1];
        assign pend  = |pl;
    end
    madd_err_acc u_acc (
        .clk         (clk),
        .rst         (rst),
        .clear       (go),
        .valid       (g_vld),
        .dut_out     (dut_out),
        .exact       (exact_madd(g_vec)),
        .vec_count   (vec_count),
        .err_count   (err_count),
        .max_abs_err (max_abs_err),
        .sum_abs_err (sum_abs_err)
    );
endmodule

// File: tb/tb_madd_err_sweep.sv
// tb_madd_err_sweep: directed checks of the sweep engine with LAT=0 and LAT=3 instances
module tb_madd_err_sweep;
    logic clk = 0, rst = 1;
    always #5 clk = ~clk;
    logic st0 = 0, ab0 = 0, st3 = 0, ab3 = 0;
    logic [17:0] vf = 0, vl = 0, din0, din3;
    logic [11:0] dout0, dout3, mx0, mx3, p1, p2, p3;
    logic busy0, done0, abd0, busy3, done3, abd3;
    logic [18:0] vc0, ec0, vc3, ec3;
    logic [29:0] sm0, sm3;
    int mode = 0;
    int compared = 0, mismatched = 0;
    int cyc;
    logic sawb, sawd;

    function automatic logic [11:0] ref_madd(input logic [17:0] v);
        int a, b, c;
        a = int'(v[5:0]);
        b = int'(v[11:6]);
        c = int'(v[17:12]);
        return 12'(a * b + c);
    endfunction

    assign dout0 = mode == 2 ? 12'd0 : mode == 1 ? (ref_madd(din0) | 12'd1) : ref_madd(din0);
    always_ff @(posedge clk) begin
        p1 <= ref_madd(din3);
        p2 <= p1;
        p3 <= p2;
    end
    assign dout3 = p3;

    madd_err_sweep #(.LAT(0)) u0 (
        .clk(clk), .rst(rst), .start(st0), .abort(ab0), .vec_first(vf), .vec_last(vl),
        .dut_in(din0), .dut_out(dout0), .busy(busy0), .done(done0), .aborted(abd0),
        .vec_count(vc0), .err_count(ec0), .max_abs_err(mx0), .sum_abs_err(sm0)
    );
    madd_err_sweep #(.LAT(3)) u3 (
        .clk(clk), .rst(rst), .start(st3), .abort(ab3), .vec_first(vf), .vec_last(vl),
        .dut_in(din3), .dut_out(dout3), .busy(busy3), .done(done3), .aborted(abd3),
        .vec_count(vc3), .err_count(ec3), .max_abs_err(mx3), .sum_abs_err(sm3)
    );

    task automatic start0(input logic [17:0] f, input logic [17:0] l);
        @(negedge clk);
        vf = f; vl = l; st0 = 1;
        @(posedge clk); #1 st0 = 0;
    endtask

    task automatic start3(input logic [17:0] f, input logic [17:0] l, input logic ab);
        @(negedge clk);
        vf = f; vl = l; st3 = 1; ab3 = ab;
        @(posedge clk); #1 st3 = 0; ab3 = 0;
    endtask

    task automatic wait_done(input bit sel, input int c0, input int limit, output int c_done, output logic saw_busy);
        c_done = 0;
        saw_busy = 0;
        for (int c = c0; c <= limit; c++) begin
            @(negedge clk);
            if (sel ? busy3 : busy0) saw_busy = 1;
            if (sel ? done3 : done0) begin
                c_done = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        compared++;
        if ({din0, busy0, done0, abd0} !== 21'd0) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %h want 0", {din0, busy0, done0, abd0});
        end
        compared++;
        if ({vc0, ec0, mx0, sm0} !== 80'd0) begin
            mismatched++;
            $display("FAIL reset_stats: got %h want 0", {vc0, ec0, mx0, sm0});
        end
        rst = 0;
    endtask

    task automatic test_exact;
        mode = 0;
        start0(18'd0, 18'd127);
        compared++;
        if (din0 !== 18'd0) begin mismatched++; $display("FAIL exact_first_vec: got %h want 0", din0); end
        wait_done(0, 1, 400, cyc, sawb);
        compared++;
        if (cyc !== 130) begin mismatched++; $display("FAIL exact_done_cycle: got %0d want 130", cyc); end
        compared++;
        if ({vc0, ec0, mx0, sm0} !== {19'd128, 19'd0, 12'd0, 30'd0}) begin
            mismatched++; $display("FAIL exact_stats: got vc=%0d ec=%0d mx=%0d sm=%0d want 128/0/0/0", vc0, ec0, mx0, sm0);
        end
        @(negedge clk);
        compared++;
        if ({busy0, done0} !== 2'b00) begin mismatched++; $display("FAIL exact_after_done: got %b want 00", {busy0, done0}); end
    endtask

    task automatic test_bit0;
        mode = 1;
        start0(18'd0, 18'd127);
        wait_done(0, 1, 400, cyc, sawb);
        compared++;
        if (cyc !== 130) begin mismatched++; $display("FAIL bit0_done_cycle: got %0d want 130", cyc); end
        compared++;
        if ({vc0, ec0, mx0, sm0} !== {19'd128, 19'd96, 12'd1, 30'd96}) begin
            mismatched++; $display("FAIL bit0_stats: got vc=%0d ec=%0d mx=%0d sm=%0d want 128/96/1/96", vc0, ec0, mx0, sm0);
        end
    endtask

    task automatic test_zero;
        mode = 2;
        start0(18'h00FC0, 18'h00FC2);
        wait_done(0, 1, 50, cyc, sawb);
        compared++;
        if (cyc !== 5) begin mismatched++; $display("FAIL zero_done_cycle: got %0d want 5", cyc); end
        compared++;
        if ({vc0, ec0, mx0, sm0} !== {19'd3, 19'd2, 12'd126, 30'd189}) begin
            mismatched++; $display("FAIL zero_stats: got vc=%0d ec=%0d mx=%0d sm=%0d want 3/2/126/189", vc0, ec0, mx0, sm0);
        end
        start0(18'h3FFFF, 18'h3FFFF);
        wait_done(0, 1, 50, cyc, sawb);
        compared++;
        if (cyc !== 3) begin mismatched++; $display("FAIL top_done_cycle: got %0d want 3", cyc); end
        compared++;
        if ({vc0, ec0, mx0, sm0} !== {19'd1, 19'd1, 12'd4032, 30'd4032}) begin
            mismatched++; $display("FAIL top_stats: got vc=%0d ec=%0d mx=%0d sm=%0d want 1/1/4032/4032", vc0, ec0, mx0, sm0);
        end
        compared++;
        if (din0 !== 18'h3FFFF) begin mismatched++; $display("FAIL top_no_wrap: got %h want 3ffff", din0); end
    endtask

    task automatic test_empty;
        mode = 0;
        start0(18'd5, 18'd4);
        wait_done(0, 1, 20, cyc, sawb);
        repeat (3) begin
            @(negedge clk);
            if (busy0) sawb = 1;
        end
        compared++;
        if (cyc !== 1) begin mismatched++; $display("FAIL empty_done_cycle: got %0d want 1", cyc); end
        compared++;
        if (sawb !== 1'b0) begin mismatched++; $display("FAIL empty_busy: got %b want 0", sawb); end
        compared++;
        if ({vc0, ec0, mx0, sm0} !== 80'd0) begin
            mismatched++; $display("FAIL empty_stats: got vc=%0d ec=%0d mx=%0d sm=%0d want 0/0/0/0", vc0, ec0, mx0, sm0);
        end
    endtask

    task automatic test_back_to_back;
        mode = 0;
        start0(18'd0, 18'd9);
        @(posedge clk); #1;
        vf = 18'd50; vl = 18'd40; st0 = 1;
        @(posedge clk); #1 st0 = 0;
        wait_done(0, 3, 100, cyc, sawb);
        compared++;
        if (cyc !== 12 || vc0 !== 19'd10) begin
            mismatched++; $display("FAIL busy_start_ignored: got cycle=%0d vc=%0d want 12/10", cyc, vc0);
        end
        start0(18'd200, 18'd203);
        wait_done(0, 1, 50, cyc, sawb);
        compared++;
        if (cyc !== 6 || vc0 !== 19'd4) begin
            mismatched++; $display("FAIL restart_from_done: got cycle=%0d vc=%0d want 6/4", cyc, vc0);
        end
    endtask

    task automatic test_abort;
        start3(18'd0, 18'd999, 1'b0);
        repeat (99) @(posedge clk);
        #1 ab3 = 1;
        @(posedge clk); #1 ab3 = 0;
        @(negedge clk);
        compared++;
        if ({busy3, abd3} !== 2'b01) begin mismatched++; $display("FAIL abort_flags: got busy/aborted=%b want 01", {busy3, abd3}); end
        sawd = done3;
        repeat (6) begin
            @(negedge clk);
            if (done3) sawd = 1;
        end
        compared++;
        if (sawd !== 1'b0) begin mismatched++; $display("FAIL abort_no_done: got %b want 0", sawd); end
        compared++;
        if (vc3 !== 19'd97 || ec3 !== 19'd0) begin
            mismatched++; $display("FAIL abort_partial: got vc=%0d ec=%0d want 97/0", vc3, ec3);
        end
        start3(18'd0, 18'd9, 1'b1);
        compared++;
        if ({busy3, abd3} !== 2'b10) begin mismatched++; $display("FAIL start_beats_abort: got busy/aborted=%b want 10", {busy3, abd3}); end
        wait_done(1, 1, 100, cyc, sawb);
        compared++;
        if (cyc !== 15 || vc3 !== 19'd10 || ec3 !== 19'd0) begin
            mismatched++; $display("FAIL lat3_sweep: got cycle=%0d vc=%0d ec=%0d want 15/10/0", cyc, vc3, ec3);
        end
    endtask

    task automatic test_reset_mid;
        mode = 1;
        start0(18'd0, 18'd127);
        repeat (20) @(posedge clk);
        #2 rst = 1;
        #1;
        compared++;
        if ({din0, busy0, done0, abd0, vc0, ec0, mx0, sm0} !== 101'd0) begin
            mismatched++; $display("FAIL reset_mid: got din=%h busy=%b vc=%0d ec=%0d want all 0", din0, busy0, vc0, ec0);
        end
        @(negedge clk) rst = 0;
        mode = 0;
        start0(18'd0, 18'd9);
        wait_done(0, 1, 100, cyc, sawb);
        compared++;
        if (cyc !== 12 || vc0 !== 19'd10 || ec0 !== 19'd0) begin
            mismatched++; $display("FAIL reset_rerun: got cycle=%0d vc=%0d ec=%0d want 12/10/0", cyc, vc0, ec0);
        end
    endtask

    initial begin
        test_reset;
        test_exact;
        test_bit0;
        test_zero;
        test_empty;
        test_back_to_back;
        test_abort;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/madd_err_sweep.md
Name: madd_err_sweep

Overview:
- Sequencer and error-statistics engine for the 18-input / 12-output multiply-add datapath, which computes out = a*b + c with 6-bit operands.
- On start, it sweeps a programmed range of input vectors through the datapath under test (DUT) and compares each result against an exact internal golden model.
- It accumulates the error count, maximum absolute error and sum of absolute errors, then pulses done.
- It sits beside each candidate approximate netlist in the error-evaluation harness.

Parameters:
- LAT, 0: register stages between dut_in and dut_out outside this block. Legal range 0..3.
- OP_W, 6: operand width for a, b and c. The input vector is 3*OP_W bits and the result is 2*OP_W bits.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  single-cycle request; sampled only in IDLE or DONE
- abort  in  1  stops an active sweep
- vec_first  in  18  first vector of the range; sampled at start
- vec_last  in  18  last vector of the range, inclusive; sampled at start
- dut_in  out  18  registered vector. [5:0]=a, [11:6]=b, [17:12]=c; bit 0 is the LSB of a.
- dut_out  in  12  DUT result; bit 0 is the LSB
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when results are final
- aborted  out  1  set on abort; cleared by the next accepted start
- vec_count  out  19  number of vectors compared
- err_count  out  19  number of vectors where dut_out != exact
- max_abs_err  out  12  largest |dut_out - exact|
- sum_abs_err  out  30  sum of |dut_out - exact|; cannot overflow

Behaviour:
- Reset (asynchronous): state=IDLE. Every output is 0, including dut_in, done, aborted and all statistics.
- States: IDLE, RUN, DRAIN, DONE.
- Cycle reference: the start cycle is cycle 0.
- IDLE/DONE + start, with vec_first <= vec_last:
  - latch the range; clear all statistics and aborted; go to RUN.
  - dut_in = vec_first in cycle 1.
- IDLE/DONE + start, with vec_first > vec_last: go to DONE; done pulses in cycle 1; all statistics are 0.
- RUN:
  - dut_in increments by 1 every cycle.
  - When dut_in == vec_last, the next state is DRAIN and dut_in holds.
  - The counter never wraps; vec_last = 0x3FFFF is legal.
- Golden path:
  - The driven vector is delayed through LAT stages in step with the DUT.
  - exact = a*b + c, 12 bits; the maximum is 4032, so it never overflows.
  - diff = dut_out - exact, 13-bit signed; abs_err = |diff|.
- Pipeline:
  - abs_err and its valid bit are registered in compare stage E.
  - Accumulators update from E on the following edge.
  - Vector k (0-based in the range) is visible in the statistics in cycle 3+k+LAT.
- DRAIN:
  - Lasts until the last vector is accumulated, then goes to DONE.
  - done pulses in cycle N+2+LAT, where N = vec_last - vec_first + 1. Statistics are final that same cycle.
- DONE: statistics hold; busy=0. A new start behaves as from IDLE.
- Accumulate rules:
  - vec_count += 1 per valid compare.
  - err_count += 1 if abs_err != 0.
  - max_abs_err = max(max_abs_err, abs_err).
  - sum_abs_err += abs_err.
- start while busy is ignored.
- abort in RUN or DRAIN:
  - next cycle state=IDLE, busy=0, aborted=1, no done pulse.
  - In-flight pipeline entries are discarded; the statistics keep their partial values.
  - abort in IDLE or DONE has no effect.
- start and abort in the same cycle while idle: start wins and abort is ignored.
- Reset mid-sweep: immediate return to the reset state; no done pulse.

Decomposition:
- Package madd_eval_pkg holds:
  - state enum and OP_W-derived widths (VEC_W=18, RES_W=12, DIFF_W=13);
  - field-slice constants for a, b and c;
  - function exact_madd(vec) returning a*b+c.
- One sub-module, madd_err_acc: the compare stage E plus the four accumulators, with clear and valid inputs.

Test Plan:
- Full range 0..0x3FFFF, DUT = exact model, LAT=0 -> done in cycle 262146; vec_count=262144; err_count=0; max=0; sum=0.
- Full range, DUT = exact with bit 0 forced 1 -> err_count=131072; max_abs_err=1; sum_abs_err=131072.
- Range 0x3FFFF..0x3FFFF, dut_out tied to 0 -> vec_count=1; err_count=1; max=4032; sum=4032; done in cycle 3; no counter wrap.
- vec_first=5, vec_last=4 -> done in cycle 1; all statistics 0; busy never asserts.
- Full range, exact DUT, LAT=3, abort asserted in cycle 100 -> busy=0 in cycle 101; aborted=1; no done; vec_count=97.
- rst asserted mid-RUN -> all outputs 0 immediately. A new start then runs range 0..9 to completion with vec_count=10.
